// File: rtl/char_scroller_pkg.sv
// Shared constants, types and helpers for the six-character scrolling display.
package char_scroller_pkg;

    localparam logic [1:0] CHAR_D     = 2'b00;
    localparam logic [1:0] CHAR_E     = 2'b01;
    localparam logic [1:0] CHAR_1     = 2'b10;
    localparam logic [1:0] CHAR_BLANK = 2'b11;

    // HEX5..HEX0 = blank, blank, blank, d, E, 1
    localparam logic [11:0] RESET_PATTERN = 12'hFC6;

    localparam int NUM_CHARS = 6;

    typedef struct packed {
        logic s1;
        logic s2;
        logic s3;
        logic live;
        logic armed;
    } step_sync_t;

    function automatic logic [11:0] rotate_codes(
        input logic [11:0] c,
        input logic        right
    );
        logic [11:0] r;
        r = right ? {c[1:0], c[11:2]} : {c[9:0], c[11:10]};
        return r;
    endfunction

    // Active-low gfedcba pattern for a downstream seven-segment digit.
    function automatic logic [6:0] char_segments(input logic [1:0] c);
        logic [6:0] seg;
        seg = 7'h7F;
        unique case (c)
            CHAR_D:  seg = 7'b0100001;
            CHAR_E:  seg = 7'b0000110;
            CHAR_1:  seg = 7'b1111001;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/char_scroller_if.sv
// Control and display bundle between the scroller and its driver.
interface char_scroller_if;
    logic        enable;
    logic        step;
    logic        dir;
    logic        load;
    logic [11:0] load_data;
    logic [11:0] codes;
    logic        tick;

    modport master (
        output enable, step, dir, load, load_data,
        input  codes, tick
    );

    modport slave (
        input  enable, step, dir, load, load_data,
        output codes, tick
    );
endinterface

// File: rtl/char_scroller_tick_gen.sv
// Prescaler: counts 0..TICK_COUNT-1 while enabled, pulses on the terminal count.
module tick_gen #(
    parameter int TICK_COUNT = 50000000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic pulse
);
    localparam int W = $clog2(TICK_COUNT);
    localparam logic [W-1:0] LAST = W'(TICK_COUNT - 1);

    logic [W-1:0] count;

    always_ff @(posedge CLOCK_50) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign pulse = enable && (count == LAST);

endmodule

// File: rtl/char_scroller.sv
// Rotating six-character message with automatic and pushbutton-stepped shifts.
module char_scroller
    import char_scroller_pkg::*;
#(
    parameter int TICK_COUNT = 50000000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        enable,
    input  logic        step,
    input  logic        dir,
    input  logic        load,
    input  logic [11:0] load_data,
    output logic [11:0] codes,
    output logic        tick
);
    step_sync_t sync_q;
    logic       step_rise;
    logic       term;
    logic       shift_now;

    // armed only after step has been seen low out of reset, so a
    // button still held across reset release never counts as a press
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q.s1    <= step;
            sync_q.s2    <= sync_q.s1;
            sync_q.s3    <= sync_q.s2;
            sync_q.live  <= 1'b1;
            sync_q.armed <= sync_q.armed | (sync_q.live & ~sync_q.s1);
        end
    end

    assign step_rise = sync_q.s2 & ~sync_q.s3 & sync_q.armed;

    tick_gen #(
        .TICK_COUNT(TICK_COUNT)
    ) u_tick_gen (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .enable  (enable),
        .clear   (load),
        .pulse   (term)
    );

    assign shift_now = ~load & (term | (step_rise & ~enable));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            codes <= RESET_PATTERN;
            tick  <= 1'b0;
        end else if (load) begin
            codes <= load_data;
            tick  <= 1'b0;
        end else begin
            tick <= shift_now;
            if (shift_now) begin
                codes <= rotate_codes(codes, dir);
            end
        end
    end

endmodule
